keccak_squeeze_stream: RTL
==========================

Name: keccak_squeeze_stream

Overview:
Parametrised squeeze controller for the Keccak/SHAKE XOF path. Streams up to outputLen bytes out of the 1600-bit state in WORD_W-bit words, using a valid/ready handshake with full backpressure. Requests one Keccak-f1600 permutation per exhausted rate block, and only when more output is still owed. Optional pause-after-block lets PRNG consumers pull output in chunks. Sits between keccak_f1600 and the PASTA sampler/output buffer.

Parameters:
WORD_W, 64, output word width in bits; legal values 32 or 64; WB = WORD_W/8 bytes per word.
LEN_W, 16, width of the output length in bytes.
SEL_W, 6, width of state_word_sel; must hold 1600/WORD_W - 1.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  pulse; latches rate_bytes, out_len, hold_en; ignored unless state is IDLE or DONE
rate_bytes  in  8  rate in bytes; multiple of WB, 8..168
out_len  in  LEN_W  total bytes to squeeze
hold_en  in  1  when 1, pause after every permutation until resume
resume  in  1  leaves HOLD
perm_start  out  1  one-cycle request to keccak_f1600
perm_done  in  1  one-cycle completion from keccak_f1600
state_word_sel  out  SEL_W  index of the WORD_W word in the state currently presented
dout_valid  out  1  state_word_sel word is valid output
dout_ready  in  1  consumer accepts the word
dout_last  out  1  qualifies the final word
busy  out  1  high in EMIT, PERM, HOLD
done  out  1  high in DONE

Behaviour:
- Reset values: all outputs 0; FSM enters IDLE; word_cnt = 0; remaining = 0.
- Registers:
  - remaining: LEN_W+1 bits; loaded with out_len on an accepted start.
  - word_cnt: SEL_W bits; cleared on start and on entry to PERM.
  - rate_last = rate_bytes/WB - 1; latched on start.
- xfer = dout_valid & dout_ready.
- IDLE: on start, go to DONE if out_len == 0, else go to EMIT.
- EMIT:
  - dout_valid = 1; state_word_sel = word_cnt; dout_last = (remaining <= WB).
  - Each xfer: remaining -= WB, saturating at 0; word_cnt += 1.
  - On xfer with dout_last = 1: go to DONE. This takes priority over the rate boundary. perm_start is never issued for output that is not needed.
  - Else, on xfer with word_cnt == rate_last: go to PERM and assert perm_start in the same cycle as the xfer (registered, one cycle).
  - No xfer: stay; state_word_sel and dout_last stay stable under backpressure.
- PERM: dout_valid = 0. On perm_done: go to HOLD if the latched hold_en = 1, else go to EMIT. Latency from the final block word's xfer to the next block's first dout_valid = permutation latency + 1 cycle.
- HOLD: dout_valid = 0. On resume go to EMIT; otherwise stay. resume outside HOLD is ignored.
- DONE: done = 1 and is held. start restarts with new inputs, DONE -> EMIT or DONE.
- perm_done outside PERM is ignored. start while busy is ignored and does not change the latched values.
- rst mid-operation: return to IDLE next cycle, all outputs deassert, and no perm_start is emitted.
- The first block is squeezed from the already-permuted absorb state; no perm_start precedes it.

Optional Feature:
KECCAK_SQZ_KEEP_EN:
- Defined: adds output dout_keep [WB-1:0], a byte-enable for the current word. It is all ones except on the dout_last word, where the low (remaining) bits are ones and the rest zeros. Example: WB = 8, 5 bytes left gives 8'h1F. It is valid whenever dout_valid = 1.
- Undefined: the port is absent, and the consumer truncates the final word using its own copy of out_len.

Test Plan:
1. WORD_W=64, rate 168, out_len 32, dout_ready=1 -> 4 consecutive dout_valid cycles, sel 0..3, dout_last on the 4th, no perm_start, done next cycle.
2. rate 168, out_len 200 -> 21 xfers (sel 0..20), then a perm_start pulse; perm_done after 24 cycles -> 4 more words sel 0..3, dout_last on sel 3. Exactly one perm_start in total.
3. rate 168, out_len 168 -> 21 words, dout_last on sel 20, no perm_start.
4. Backpressure: out_len 24, dout_ready toggles 1,0,0,1,0,1 -> sel advances only on xfer cycles, dout_valid never drops, 3 words total. With KECCAK_SQZ_KEEP_EN, out_len 13 gives dout_keep 8'hFF then 8'h1F.
5. hold_en=1, rate 136, out_len 300 -> after 17 words and perm_done, HOLD with dout_valid=0 for 10 cycles; resume -> sel restarts at 0.
6. out_len 0 -> no dout_valid, DONE one cycle after start. rst asserted mid-EMIT -> outputs 0 next cycle, IDLE; a later start behaves as in scenario 1.

Source files
------------

// File: rtl/keccak_squeeze_stream.sv
// keccak_squeeze_stream: streams out_len bytes from the Keccak state in WORD_W words, requesting a permutation per exhausted rate block; optional dout_keep via KECCAK_SQZ_KEEP_EN
module keccak_squeeze_stream #(
  parameter int WORD_W = 64,
  parameter int LEN_W  = 16,
  parameter int SEL_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [7:0]       i_rate_bytes,
  input  logic [LEN_W-1:0] i_out_len,
  input  logic             i_hold_en,
  input  logic             i_resume,
  output logic             o_perm_start,
  input  logic             i_perm_done,
  output logic [SEL_W-1:0] o_state_word_sel,
  output logic             o_dout_valid,
  input  logic             i_dout_ready,
  output logic             o_dout_last,
  output logic             o_busy,
  output logic             o_done
`ifdef KECCAK_SQZ_KEEP_EN
  ,output logic [WORD_W/8-1:0] o_dout_keep
`endif
);
  localparam int WB = WORD_W / 8;
  localparam int KW = $clog2(WB);
  localparam logic [LEN_W:0] WB_L = (LEN_W + 1)'(WB);
  typedef enum logic [2:0] {IDLE, EMIT, PERM, HOLD, DONE} state_t;
  state_t r_state, w_state_d;
  logic [LEN_W:0] r_remaining;
  logic [SEL_W-1:0] r_word_cnt, r_rate_last;
  logic r_hold_en, r_perm_start;
  logic w_xfer, w_last, w_load, w_perm_req;
  logic [7:0] w_rate_words;
  assign w_rate_words = i_rate_bytes >> KW;
  assign w_last = r_remaining <= WB_L;
  assign w_load = i_start & (r_state == IDLE | r_state == DONE);
  assign o_dout_valid = r_state == EMIT;
  assign w_xfer = o_dout_valid & i_dout_ready;
  assign o_dout_last = o_dout_valid & w_last;
  assign o_state_word_sel = r_word_cnt;
  assign o_perm_start = r_perm_start;
  assign o_busy = r_state == EMIT | r_state == PERM | r_state == HOLD;
  assign o_done = r_state == DONE;
`ifdef KECCAK_SQZ_KEEP_EN
  // shifting all-ones by remaining leaves exactly the low remaining bytes enabled; remaining == WB shifts to zero, i.e. full word
  assign o_dout_keep = !o_dout_valid ? '0 : w_last ? ~({WB{1'b1}} << r_remaining[KW:0]) : '1;
`endif
  always_comb begin
    w_state_d = r_state;
    w_perm_req = 1'b0;
    case (r_state)
      IDLE, DONE: if (i_start) w_state_d = (i_out_len == '0) ? DONE : EMIT;
      EMIT: if (w_xfer) begin
        // the final word wins over the rate boundary so no unneeded permutation is requested
        w_state_d = w_last ? DONE : (r_word_cnt == r_rate_last) ? PERM : EMIT;
        w_perm_req = !w_last && r_word_cnt == r_rate_last;
      end
      PERM: if (i_perm_done) w_state_d = r_hold_en ? HOLD : EMIT;
      HOLD: if (i_resume) w_state_d = EMIT;
      default: w_state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_remaining <= '0;
      r_word_cnt <= '0;
      r_rate_last <= '0;
      r_hold_en <= 1'b0;
      r_perm_start <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_perm_start <= w_perm_req;
      if (w_load) begin
        r_remaining <= {1'b0, i_out_len};
        r_word_cnt <= '0;
        r_rate_last <= SEL_W'(w_rate_words - 8'd1);
        r_hold_en <= i_hold_en;
      end else if (w_xfer) begin
        r_remaining <= w_last ? '0 : r_remaining - WB_L;
        r_word_cnt <= w_perm_req ? '0 : r_word_cnt + SEL_W'(1);
      end
    end
  end
endmodule
